tl_state_out: RTL and testbench
===============================

TL_STATE_OUT -- requirements
Module: tl_state_out

Interface
REQ-001 Parameter YEL_CYC, default 4, clock cycles spent in each yellow state (S1, S3, S5, S7), legal range 1..255.
REQ-002 Parameter MIN_GRN_CYC, default 8, minimum clock cycles in each green or left state (S0, S2, S4, S6), legal range 1..255.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 d  input  3  requested next state from the next-state logic.
REQ-006 q  output  3  registered current state, fed back to the next-state logic.
REQ-007 La  output  2  street A light: 00 green, 01 yellow, 10 left, 11 red.
REQ-008 Lb  output  2  street B light, same encoding as La.
REQ-009 chg  output  1  one-cycle pulse in the first cycle of a new state.
REQ-010 err  output  1  one-cycle pulse flagging an illegal d request.

Function
REQ-011 The block SHALL hold an 8-bit dwell counter cnt that is cleared to 0 on every state load and otherwise increments each cycle, saturating at 255.
REQ-012 A request is legal when d equals q (hold) or d equals q+1 modulo 8 (advance); 7 -> 0 wrap is a legal advance.
REQ-013 dwell_ok SHALL be true in an odd state when cnt equals YEL_CYC-1, and in an even state when cnt is at least MIN_GRN_CYC-1.
REQ-014 At a rising edge, q SHALL load d only when d is a legal advance and dwell_ok is true; otherwise q holds.
REQ-015 A legal advance requested before dwell_ok SHALL be held off, and q SHALL load it on the first edge where dwell_ok is true and d still requests it.
REQ-016 An illegal d (neither q nor q+1) SHALL leave q and cnt unchanged, except that cnt continues its normal increment, and SHALL raise err in the following cycle.
REQ-017 chg SHALL be 1 in the cycle immediately after a load and 0 otherwise.
REQ-018 err SHALL be registered, set for one cycle per illegal sample, and repeat each cycle while d stays illegal.
REQ-019 Each yellow state SHALL last exactly YEL_CYC cycles, and each even state SHALL last at least MIN_GRN_CYC cycles.
REQ-020 La and Lb SHALL be a combinational decode of registered q, so lights change in the same cycle as q.
REQ-021 Light decode: S0 A=00 B=11; S1 A=01 B=11; S2 A=10 B=11; S3 A=01 B=11; S4 A=11 B=00; S5 A=11 B=01; S6 A=11 B=10; S7 A=11 B=01.
REQ-022 La and Lb SHALL never both be non-red in any cycle.
REQ-023 The block SHALL contain no latches, and all registers SHALL be clocked only by clk.

Reset
REQ-024 While reset_n=0 at a rising edge, q SHALL become 000, cnt 0, chg 0 and err 0, which gives La=00 and Lb=11.
REQ-025 Reset SHALL override any pending advance or err, including a reset asserted mid-yellow.
REQ-026 The first cycle after reset release SHALL count as cycle 0 of S0, and chg SHALL stay 0 for that cycle.

Verification (YEL_CYC=4, MIN_GRN_CYC=8)
REQ-027 Hold in green: reset, then d=001 from cycle 0 -> q=000 for cycles 0-7, q=001 at cycle 8, chg=1 at cycle 8.
REQ-028 Exact yellow: in S1 with d=010 held -> q=001 for exactly 4 cycles, then 010, La goes 01 -> 10.
REQ-029 Extended green: in S4 with d=100 for 20 cycles, then d=101 -> q advances on the first edge after d=101, cnt saturation not reached, Lb 00 -> 01.
REQ-030 Wrap and illegal request: in S7 after 4 cycles with d=000 -> q=000, La=00, Lb=11; in S2 with d=110 -> q holds 010 and err pulses each cycle.
REQ-031 Reset mid-yellow: in S5 at cnt=2, pulse reset_n=0 for 1 cycle -> next cycle q=000, chg=0, err=0, La=00, Lb=11.
REQ-032 Full loop with d=q+1 always -> the sequence S0..S7 repeats with period 4*8+4*4=48 cycles, and REQ-022 holds in every cycle.

Source files
------------

// File: rtl/tl_state_out.sv
// Traffic-light state register: gates requested state changes on legality and
// dwell time, and decodes the registered state into the two street lights.
module tl_state_out #(
    parameter int unsigned YEL_CYC     = 4,
    parameter int unsigned MIN_GRN_CYC = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] d,
    output logic [2:0] q,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic       chg,
    output logic       err
);

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [2:0] S5 = 3'd5;
    localparam logic [2:0] S6 = 3'd6;
    localparam logic [2:0] S7 = 3'd7;

    localparam logic [1:0] L_GRN  = 2'b00;
    localparam logic [1:0] L_YEL  = 2'b01;
    localparam logic [1:0] L_LEFT = 2'b10;
    localparam logic [1:0] L_RED  = 2'b11;

    localparam logic [7:0] YEL_LAST = 8'(YEL_CYC - 1);
    localparam logic [7:0] GRN_LAST = 8'(MIN_GRN_CYC - 1);
    localparam logic [7:0] CNT_MAX  = 8'hFF;

    logic [2:0] q_q, q_d;
    logic [7:0] cnt_q, cnt_d;
    logic       chg_q, chg_d;
    logic       err_q, err_d;

    logic [2:0] q_inc;
    logic       req_hold;
    logic       req_adv;
    logic       dwell_ok;
    logic       load;

    assign q_inc    = q_q + 3'd1;
    assign req_hold = (d == q_q);
    assign req_adv  = (d == q_inc);

    // Yellow must end exactly on its last cycle; green/left may be extended.
    assign dwell_ok = q_q[0] ? (cnt_q == YEL_LAST) : (cnt_q >= GRN_LAST);
    assign load     = req_adv && dwell_ok;

    always_comb begin
        q_d   = q_q;
        cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 8'd1;
        chg_d = 1'b0;
        err_d = !(req_hold || req_adv);
        if (load) begin
            q_d   = d;
            cnt_d = '0;
            chg_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_q   <= S0;
            cnt_q <= '0;
            chg_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
            chg_q <= chg_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        La = L_RED;
        Lb = L_RED;
        case (q_q)
            S0: La = L_GRN;
            S1: La = L_YEL;
            S2: La = L_LEFT;
            S3: La = L_YEL;
            S4: Lb = L_GRN;
            S5: Lb = L_YEL;
            S6: Lb = L_LEFT;
            S7: Lb = L_YEL;
            default: begin
                La = L_RED;
                Lb = L_RED;
            end
        endcase
    end

    assign q   = q_q;
    assign chg = chg_q;
    assign err = err_q;

endmodule

// File: tb/tb_tl_state_out.sv
// Bench for tl_state_out: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a dwell-time model.
module tb_tl_state_out;

    localparam int YEL = 4;
    localparam int MIN = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] d = 3'd0;
    logic [2:0] q;
    logic [1:0] La, Lb;
    logic       chg, err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // model: current state, cycles spent in it, pulse expectations
    int m_q = 0;
    int m_age = 0;
    int m_chg = 0;
    int m_err = 0;
    int la_tab[8] = '{0, 1, 2, 1, 3, 3, 3, 3};
    int lb_tab[8] = '{3, 3, 3, 3, 0, 1, 2, 1};

    tl_state_out #(.YEL_CYC(YEL), .MIN_GRN_CYC(MIN)) dut (
        .clk(clk), .reset_n(reset_n), .d(d), .q(q),
        .La(La), .Lb(Lb), .chg(chg), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        int req, nxt, ok, age_sat;
        req = int'(d);
        nxt = (m_q + 1) % 8;
        if (!reset_n) begin
            m_q = 0; m_age = 0; m_chg = 0; m_err = 0;
        end else begin
            age_sat = (m_age > 255) ? 255 : m_age;
            if (m_q % 2 == 1) ok = (age_sat == YEL - 1);
            else              ok = (age_sat >= MIN - 1);
            m_err = (req != m_q && req != nxt) ? 1 : 0;
            if (req == nxt && ok) begin
                m_q = req; m_age = 0; m_chg = 1;
            end else begin
                m_age++; m_chg = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check("q", int'(q), m_q);
        check("La", int'(La), la_tab[m_q]);
        check("Lb", int'(Lb), lb_tab[m_q]);
        check("chg", int'(chg), m_chg);
        check("err", int'(err), m_err);
        check("both_non_red", (La != 2'b11 && Lb != 2'b11) ? 1 : 0, 0);
    endtask

    // Request each state in turn until the model reaches target, bounded.
    task automatic goto_state(input int target);
        int n = 0;
        while (m_q != target && n < 600) begin
            d = 3'((m_q + 1) % 8);
            step();
            n++;
        end
        check("goto_timeout", m_q, target);
    endtask

    initial begin
        int k, s0_last, s0_seen, r;

        // reset held with arbitrary request
        reset_n = 1'b0; d = 3'd5;
        step();
        step();
        check("rst_q", int'(q), 0);
        check("rst_La", int'(La), 0);
        check("rst_Lb", int'(Lb), 3);
        check("rst_chg", int'(chg), 0);
        check("rst_err", int'(err), 0);

        // hold in green: cycle 0 is now; advance requested from cycle 0
        reset_n = 1'b1; d = 3'd1;
        for (k = 1; k <= 8; k++) begin
            step();
            if (k <= 7) check("grn_hold_q", int'(q), 0);
        end
        check("grn_adv_q", int'(q), 1);
        check("grn_adv_chg", int'(chg), 1);

        // exact yellow length
        d = 3'd2;
        for (k = 1; k <= 3; k++) begin
            step();
            check("yel_hold_q", int'(q), 1);
            check("yel_La", int'(La), 1);
        end
        step();
        check("yel_end_q", int'(q), 2);
        check("yel_end_La", int'(La), 2);

        // extended green in S4
        goto_state(4);
        d = 3'd4;
        for (k = 0; k < 20; k++) step();
        check("ext_q", int'(q), 4);
        check("ext_Lb", int'(Lb), 0);
        d = 3'd5;
        step();
        check("ext_adv_q", int'(q), 5);
        check("ext_adv_Lb", int'(Lb), 1);

        // wrap 7 -> 0
        goto_state(7);
        d = 3'd0;
        for (k = 0; k < 4; k++) step();
        check("wrap_q", int'(q), 0);
        check("wrap_La", int'(La), 0);
        check("wrap_Lb", int'(Lb), 3);

        // illegal request in S2
        goto_state(2);
        d = 3'd6;
        for (k = 0; k < 3; k++) begin
            step();
            check("ill_q", int'(q), 2);
            check("ill_err", int'(err), 1);
        end

        // reset mid-yellow in S5 at dwell count 2
        goto_state(5);
        d = 3'd5;
        step();
        step();
        reset_n = 1'b0;
        step();
        check("midrst_q", int'(q), 0);
        check("midrst_chg", int'(chg), 0);
        check("midrst_err", int'(err), 0);
        check("midrst_La", int'(La), 0);
        check("midrst_Lb", int'(Lb), 3);
        reset_n = 1'b1;

        // full loop: every S0 entry by wrap is 48 cycles apart
        s0_last = -1; s0_seen = 0;
        for (k = 0; k < 160; k++) begin
            d = 3'((m_q + 1) % 8);
            step();
            if (chg && q == 3'd0) begin
                if (s0_last >= 0) check("loop_period", cyc - s0_last, 48);
                s0_last = cyc;
                s0_seen++;
            end
        end
        check("loop_wraps_seen", (s0_seen >= 2) ? 1 : 0, 1);

        // randomized requests, mostly legal advances
        for (k = 0; k < 4000; k++) begin
            r = int'($urandom_range(99));
            reset_n = ($urandom_range(99) == 0) ? 1'b0 : 1'b1;
            if (r < 70)      d = 3'((m_q + 1) % 8);
            else if (r < 88) d = 3'(m_q);
            else             d = 3'($urandom_range(7));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
